mesh_west_feeder: RTL

//  Upstream stage of conv_mesh. Buffers one ROWS x COLS pixel tile arriving as a
//  row-major valid/ready stream. Replays it into the mesh west edge as a diagonally

---
 rtl/mesh_west_feeder.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mesh_west_feeder.sv
// Buffers one ROWS x COLS pixel tile from a row-major stream, then replays it into the
// mesh west edge as a diagonal wavefront (lane r delayed r steps).
module mesh_west_feeder #(
   parameter int ROWS = 8,
   parameter int COLS = 8,
   parameter int DW   = 8
) (
   input  logic               ck,
   input  logic               res,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DW-1:0]      in_data,
   input  logic               in_last,
   input  logic               mesh_en,
   output logic [ROWS*DW-1:0] west_data,
   output logic [ROWS-1:0]    west_valid,
   output logic               tile_done,
   output logic               err
);

   localparam int N  = ROWS * COLS;
   localparam int CW = $clog2(N + 1);
   localparam int AW = $clog2(N);
   localparam int SW = $clog2(COLS + ROWS);
   localparam logic [SW-1:0] LAST_STEP = SW'(COLS + ROWS - 2);
   localparam logic [CW-1:0] FULL_FILL = CW'(N);
   localparam logic [CW-1:0] LAST_ADDR = CW'(N - 1);

   typedef enum logic {LOAD, DRAIN} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      wrCnt_q, wrCnt_d;
   logic [CW-1:0]      fill_q, fill_d;
   logic [SW-1:0]      step_q, step_d;
   logic [ROWS*DW-1:0] westData_q, westData_d;
   logic [ROWS-1:0]    westValid_q, westValid_d;
   logic               tileDone_q, tileDone_d;
   logic               err_q, err_d;
   logic [DW-1:0]      pixBuf_q [N];
   logic               accept;
   int                 stepInt;

   function automatic logic [AW-1:0] bufAddr(input int lane, input int s);
      int a;
      a = lane * COLS + s - lane;
      return a[AW-1:0];
   endfunction

   assign in_ready   = (state_q == LOAD) && !res;
   assign accept     = in_valid && in_ready;
   assign west_data  = westData_q;
   assign west_valid = westValid_q;
   assign tile_done  = tileDone_q;
   assign err        = err_q;

   // Tile storage; no reset needed because reads beyond fill are forced to zero.
   always_ff @(posedge ck) begin
      if (!res && accept) begin
         pixBuf_q[wrCnt_q[AW-1:0]] <= in_data;
      end
   end

   always_comb begin
      state_d     = state_q;
      wrCnt_d     = wrCnt_q;
      fill_d      = fill_q;
      step_d      = step_q;
      westData_d  = westData_q;
      westValid_d = westValid_q;
      tileDone_d  = 1'b0;
      err_d       = 1'b0;
      stepInt     = int'(step_q);
      case (state_q)
         LOAD: begin
            if (accept) begin
               wrCnt_d = wrCnt_q + 1'b1;
               if (wrCnt_q == LAST_ADDR) begin
                  state_d = DRAIN;
                  fill_d  = FULL_FILL;
                  err_d   = !in_last;
               end else if (in_last) begin
                  state_d = DRAIN;
                  fill_d  = wrCnt_q + 1'b1;
                  err_d   = 1'b1;
               end
            end
         end
         DRAIN: begin
            // The cycle showing tile_done is followed by an unconditional return to LOAD.
            if (tileDone_q) begin
               state_d     = LOAD;
               wrCnt_d     = '0;
               step_d      = '0;
               westValid_d = '0;
               westData_d  = '0;
            end else if (mesh_en) begin
               for (int r = 0; r < ROWS; r++) begin
                  westValid_d[r]         = 1'b0;
                  westData_d[r*DW +: DW] = '0;
                  if ((stepInt >= r) && (stepInt - r < COLS)) begin
                     westValid_d[r] = 1'b1;
                     if (r * COLS + stepInt - r < int'(fill_q)) begin
                        westData_d[r*DW +: DW] = pixBuf_q[bufAddr(r, stepInt)];
                     end
                  end
               end
               if (step_q == LAST_STEP) begin
                  tileDone_d = 1'b1;
               end else begin
                  step_d = step_q + 1'b1;
               end
            end
         end
         default: state_d = LOAD;
      endcase
   end

   always_ff @(posedge ck) begin
      if (res) begin
         state_q     <= LOAD;
         wrCnt_q     <= '0;
         fill_q      <= '0;
         step_q      <= '0;
         westData_q  <= '0;
         westValid_q <= '0;
         tileDone_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wrCnt_q     <= wrCnt_d;
         fill_q      <= fill_d;
         step_q      <= step_d;
         westData_q  <= westData_d;
         westValid_q <= westValid_d;
         tileDone_q  <= tileDone_d;
         err_q       <= err_d;
      end
   end

endmodule
